// File: rtl/seq_detect_pkg.sv
// ============================================================================
// Module : seq_detect_pkg
// Brief  : Elaboration-time helpers for the parametrised Moore detector.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package seq_detect_pkg;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

    function automatic logic bit_at(input logic [31:0] vec, input int idx);
        logic [31:0] t;
        t = vec >> idx;
        return t[0];
    endfunction

    // Pattern bit i counted from the first bit received (the MSB).
    function automatic logic pat_bit(input logic [15:0] pat, input int len, input int i);
        return bit_at(32'(pat), len - 1 - i);
    endfunction

    // KMP transition: longest pattern prefix that ends the string (k matched bits, ip).
    function automatic int next_state(input int k, input logic ip,
                                      input logic [15:0] pat, input int len);
        logic [31:0] s;
        int          jmax;
        logic        match;
        s = '0;
        for (int i = 0; i < k; i++) s = {s[30:0], pat_bit(pat, len, i)};
        s = {s[30:0], ip};
        jmax = (k + 1 < len) ? k + 1 : len;
        for (int j = jmax; j >= 1; j--) begin
            match = 1'b1;
            for (int i = 0; i < j; i++)
                if (bit_at(s, j - 1 - i) != pat_bit(pat, len, i)) match = 1'b0;
            if (match) return j;
        end
        return 0;
    endfunction

    function automatic int border(input logic [15:0] pat, input int len);
        logic match;
        for (int j = len - 1; j >= 1; j--) begin
            match = 1'b1;
            for (int i = 0; i < j; i++)
                if (pat_bit(pat, len, i) != pat_bit(pat, len, len - j + i)) match = 1'b0;
            if (match) return j;
        end
        return 0;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sat_counter.sv
// ============================================================================
// Module : sat_counter
// Brief  : Saturating up-counter; clear and increment together yield 1.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] c_MAX = '1;

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= inc ? CNT_W'(1) : '0;
        end else if (inc && (r_count != c_MAX)) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/seq_detect_moore_param.sv
// ============================================================================
// Module : seq_detect_moore_param
// Brief  : Parametrised Moore serial-pattern detector with overlap mode,
//          input qualifier and saturating match counter.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_detect_moore_param
    import seq_detect_pkg::*;
#(
    parameter int                 PAT_LEN = 4,
    parameter logic [PAT_LEN-1:0] PATTERN = 4'b1001,
    parameter int                 CNT_W   = 8,
    localparam int                ST_W    = clog2(PAT_LEN + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ip,
    input  logic             en,
    input  logic             overlap,
    input  logic             cnt_clr,
    output logic             op,
    output logic [CNT_W-1:0] match_cnt,
    output logic [ST_W-1:0]  state
);

    if ((PAT_LEN < 2) || (PAT_LEN > 16)) begin : g_len_check
        $error("seq_detect_moore_param: PAT_LEN must be within 2..16");
    end

    localparam int              c_TBL_N  = 2 ** (ST_W + 1);
    localparam logic [ST_W-1:0] c_S0     = '0;
    localparam logic [ST_W-1:0] c_DETECT = ST_W'(PAT_LEN);
    localparam logic [ST_W-1:0] c_BORDER = ST_W'(border(16'(PATTERN), PAT_LEN));

    // Transition ROM indexed by {state, ip}; rows beyond the last real state are never selected.
    logic [ST_W-1:0] w_tbl [c_TBL_N];

    for (genvar gi = 0; gi < c_TBL_N; gi++) begin : g_tbl
        localparam int   c_K = gi / 2;
        localparam logic c_B = ((gi % 2) == 1);
        if (c_K < PAT_LEN) begin : g_live
            assign w_tbl[gi] = ST_W'(next_state(c_K, c_B, 16'(PATTERN), PAT_LEN));
        end else begin : g_unused
            assign w_tbl[gi] = '0;
        end
    end

    logic [ST_W-1:0] r_state;
    logic            r_op;
    logic [ST_W-1:0] w_src;
    logic [ST_W-1:0] w_next;
    logic            w_hit;

    // Leaving DETECT behaves as if from the border state (overlap) or from S0 (consumed).
    assign w_src  = (r_state == c_DETECT) ? (overlap ? c_BORDER : c_S0) : r_state;
    assign w_next = w_tbl[{w_src, ip}];
    assign w_hit  = en && (w_next == c_DETECT);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_S0;
            r_op    <= 1'b0;
        end else if (en) begin
            r_state <= w_next;
            r_op    <= (w_next == c_DETECT);
        end
    end

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk   (clk),
        .rst   (reset),
        .inc   (w_hit),
        .clr   (cnt_clr),
        .count (match_cnt)
    );

    assign op    = r_op;
    assign state = r_state;

endmodule

`default_nettype wire

// File: tb/tb_seq_detect_moore_param.sv
// ============================================================================
// Module : tb_seq_detect_moore_param
// Brief  : Three detector configurations checked against a history-based model.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seq_detect_moore_param;

    logic clk = 1'b0;
    logic reset, ip, en, overlap, cnt_clr;

    logic       op0, op1, op2;
    logic [2:0] st0, st2;
    logic [1:0] st1;
    logic [7:0] cnt0, cnt1;
    logic [1:0] cnt2;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    seq_detect_moore_param u_d0 (
        .clk(clk), .reset(reset), .ip(ip), .en(en), .overlap(overlap), .cnt_clr(cnt_clr),
        .op(op0), .match_cnt(cnt0), .state(st0)
    );

    seq_detect_moore_param #(.PAT_LEN(3), .PATTERN(3'b111)) u_d1 (
        .clk(clk), .reset(reset), .ip(ip), .en(en), .overlap(overlap), .cnt_clr(cnt_clr),
        .op(op1), .match_cnt(cnt1), .state(st1)
    );

    seq_detect_moore_param #(.CNT_W(2)) u_d2 (
        .clk(clk), .reset(reset), .ip(ip), .en(en), .overlap(overlap), .cnt_clr(cnt_clr),
        .op(op2), .match_cnt(cnt2), .state(st2)
    );

    // Model: bits received since the last consumed match; state is the longest
    // pattern prefix ending that history.
    int          c_len [3] = '{4, 3, 4};
    logic [15:0] c_pat [3] = '{16'h9, 16'h7, 16'h9};
    int          c_max [3] = '{255, 255, 3};
    logic [63:0] m_hist[3];
    int          m_hl  [3];
    int          m_st  [3];
    int          m_cnt [3];

    function automatic int m_state(input logic [63:0] h, input int hl,
                                   input logic [15:0] pat, input int len);
        logic [63:0] hb;
        logic [15:0] pb;
        logic        ok;
        for (int j = (hl < len ? hl : len); j >= 1; j--) begin
            ok = 1'b1;
            for (int i = 0; i < j; i++) begin
                hb = h >> (j - 1 - i);
                pb = pat >> (len - 1 - i);
                if (hb[0] != pb[0]) ok = 1'b0;
            end
            if (ok) return j;
        end
        return 0;
    endfunction

    task automatic m_update(input int i, input logic b, e, ov, clr, rs);
        logic inc;
        if (rs) begin
            m_hist[i] = '0; m_hl[i] = 0; m_st[i] = 0; m_cnt[i] = 0;
        end else begin
            inc = 1'b0;
            if (e) begin
                if (m_st[i] == c_len[i] && !ov) m_hl[i] = 0;
                m_hist[i] = {m_hist[i][62:0], b};
                m_hl[i]   = (m_hl[i] < 32) ? m_hl[i] + 1 : 32;
                m_st[i]   = m_state(m_hist[i], m_hl[i], c_pat[i], c_len[i]);
                inc       = (m_st[i] == c_len[i]);
            end
            if (clr) m_cnt[i] = inc ? 1 : 0;
            else if (inc && m_cnt[i] < c_max[i]) m_cnt[i]++;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("d0_op",  32'(op0),  32'(m_st[0] == c_len[0]));
        chk("d0_st",  32'(st0),  32'(m_st[0]));
        chk("d0_cnt", 32'(cnt0), 32'(m_cnt[0]));
        chk("d1_op",  32'(op1),  32'(m_st[1] == c_len[1]));
        chk("d1_st",  32'(st1),  32'(m_st[1]));
        chk("d1_cnt", 32'(cnt1), 32'(m_cnt[1]));
        chk("d2_op",  32'(op2),  32'(m_st[2] == c_len[2]));
        chk("d2_st",  32'(st2),  32'(m_st[2]));
        chk("d2_cnt", 32'(cnt2), 32'(m_cnt[2]));
    endtask

    task automatic step(input logic b, e, ov, clr, rs);
        ip = b; en = e; overlap = ov; cnt_clr = clr; reset = rs;
        @(posedge clk);
        for (int i = 0; i < 3; i++) m_update(i, b, e, ov, clr, rs);
        #1;
        check_all();
    endtask

    task automatic send(input logic [31:0] bits, input int n, input logic ov);
        for (int k = n - 1; k >= 0; k--) step(bits[k], 1'b1, ov, 1'b0, 1'b0);
    endtask

    initial begin
        logic [31:0] v;
        reset = 1'b1; ip = 1'b0; en = 1'b0; overlap = 1'b1; cnt_clr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            m_hist[i] = '0; m_hl[i] = 0; m_st[i] = 0; m_cnt[i] = 0;
        end

        // Reset state
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("rst_op", 32'(op0), 32'd0);

        // Long mixed stream, overlap on: matches end at bits 8 and 19
        send(32'b0100010010111010100101, 22, 1'b1);
        chk("tp1_cnt", 32'(cnt0), 32'd2);

        // 1001001 in overlap and non-overlap modes
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        send(32'b1001001, 7, 1'b1);
        chk("ovl_cnt", 32'(cnt0), 32'd2);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        send(32'b1001001, 7, 1'b0);
        chk("novl_cnt", 32'(cnt0), 32'd1);

        // 111 detector on five ones
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        send(32'b11111, 5, 1'b1);
        chk("p111_cnt", 32'(cnt1), 32'd3);
        chk("p111_op", 32'(op1), 32'd1);

        // en gaps: mid-pattern and while in DETECT
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        send(32'b10, 2, 1'b1);
        for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("gap_st", 32'(st0), 32'd2);
        send(32'b01, 2, 1'b1);
        for (int k = 0; k < 2; k++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("gap_op", 32'(op0), 32'd1);
        chk("gap_cnt", 32'(cnt0), 32'd1);

        // Counter saturation at CNT_W=2, then clear interactions
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        for (int n = 1; n <= 6; n++) begin
            send(32'b1001, 4, 1'b1);
            chk("sat_cnt", 32'(cnt2), 32'((n < 3) ? n : 3));
        end
        send(32'b100, 3, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("clr_inc", 32'(cnt2), 32'd1);
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("clr_only", 32'(cnt2), 32'd0);

        // Reset while in S3 with ip=1
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        send(32'b100, 3, 1'b1);
        chk("s3_st", 32'(st0), 32'd3);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        chk("mid_rst_st", 32'(st0), 32'd0);
        chk("mid_rst_op", 32'(op0), 32'd0);
        send(32'b001, 3, 1'b1);
        chk("post_rst_op", 32'(op0), 32'd0);

        // Randomised traffic
        for (int k = 0; k < 1500; k++) begin
            v = $urandom;
            step(v[0], (v[3:1] != 3'd0), v[4], (v[9:5] == 5'd0), (v[16:10] == 7'd0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
